// File: rtl/sys_ctrl_pkg.sv
// Shared command codes, FSM encoding and state classification for the host
// command responder.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_WR = 8'hAA;
  localparam logic [7:0] CMD_RD = 8'hBB;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_TX_SEND = 3'd5
  } state_e;

  // States that are waiting on the host or the register file and may abort.
  function automatic logic is_timed_state(input state_e st);
    logic timed;
    case (st)
      ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_RD_WAIT: timed = 1'b1;
      default:                                        timed = 1'b0;
    endcase
    return timed;
  endfunction

endpackage

// File: rtl/sys_ctrl_timer.sv
// Inter-byte idle timer: counts while enabled, saturates at TIMEOUT and
// flags expiry for the cycle the count sits at TIMEOUT.
module frame_timer #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int            CW    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear has priority, then saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CW{1'b0}};
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/sys_ctrl.sv
// Host command responder: decodes write/read frames from the UART receiver,
// drives the register-file strobes and returns read data to the UART transmitter.
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_Valid,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_Busy,
  output logic                  Frame_Err
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wrdata_q, wrdata_d;
  logic [DATA_WIDTH-1:0] txdata_q, txdata_d;
  logic                  wren_q, wren_d;
  logic                  rden_q, rden_d;
  logic                  txvld_q, txvld_d;
  logic                  ferr_q, ferr_d;
  logic                  rx_accept_s;
  logic                  addr_ok_s;
  logic                  expired_s;
  logic                  tmr_clr_s;
  logic                  tmr_en_s;

  // Only the low ADDR_WIDTH bits may be set in an address byte.
  assign addr_ok_s = ((RX_P_DATA >> ADDR_WIDTH) == {DATA_WIDTH{1'b0}});
  assign tmr_en_s  = is_timed_state(state_q);
  assign tmr_clr_s = rx_accept_s || (state_d != state_q);

  frame_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i    (CLK),
    .rst_i    (RST),
    .clr_i    (tmr_clr_s),
    .en_i     (tmr_en_s),
    .expired_o(expired_s)
  );

  // Frame decode: next state, latched fields and single-cycle strobes.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wrdata_d    = wrdata_q;
    txdata_d    = txdata_q;
    wren_d      = 1'b0;
    rden_d      = 1'b0;
    txvld_d     = 1'b0;
    ferr_d      = 1'b0;
    rx_accept_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          rx_accept_s = 1'b1;
          if (RX_P_DATA == DATA_WIDTH'(CMD_WR)) begin
            state_d = ST_WR_ADDR;
          end else if (RX_P_DATA == DATA_WIDTH'(CMD_RD)) begin
            state_d = ST_RD_ADDR;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_ADDR, ST_RD_ADDR: begin
        if (expired_s) begin
          ferr_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (RX_D_VLD) begin
          rx_accept_s = 1'b1;
          if (!addr_ok_s) begin
            ferr_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (state_q == ST_WR_ADDR) begin
            addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
            state_d = ST_WR_DATA;
          end else begin
            addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
            rden_d  = 1'b1;
            state_d = ST_RD_WAIT;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_WR_DATA: begin
        if (expired_s) begin
          ferr_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (RX_D_VLD) begin
          rx_accept_s = 1'b1;
          wrdata_d    = RX_P_DATA;
          wren_d      = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_WR_DATA;
        end
      end
      ST_RD_WAIT: begin
        // Host bytes arriving here are dropped without clearing the timer.
        if (expired_s) begin
          ferr_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (RdData_Valid) begin
          txdata_d = RdData;
          state_d  = ST_TX_SEND;
        end else begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_TX_SEND: begin
        if (!TX_Busy) begin
          txvld_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_TX_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      addr_q   <= {ADDR_WIDTH{1'b0}};
      wrdata_q <= {DATA_WIDTH{1'b0}};
      txdata_q <= {DATA_WIDTH{1'b0}};
      wren_q   <= 1'b0;
      rden_q   <= 1'b0;
      txvld_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      txdata_q <= txdata_d;
      wren_q   <= wren_d;
      rden_q   <= rden_d;
      txvld_q  <= txvld_d;
      ferr_q   <= ferr_d;
    end
  end

  assign WrEn      = wren_q;
  assign RdEn      = rden_q;
  assign Address   = addr_q;
  assign WrData    = wrdata_q;
  assign TX_P_DATA = txdata_q;
  assign TX_D_VLD  = txvld_q;
  assign Frame_Err = ferr_q;

endmodule
